// File: rtl/mux_t_pkg.sv
// rtl/mux_t_pkg.sv - shared types, widths and mode decode for the multi-channel temporal mux
package mux_t_pkg;

    typedef enum logic [1:0] {
        MODE_RISE = 2'b00,
        MODE_FALL = 2'b01,
        MODE_PW   = 2'b10
    } mode_t;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DONE
    } chan_state_t;

    localparam int GAMMA_DEFAULT = 16;
    localparam int CNT_W_DEFAULT = $clog2(GAMMA_DEFAULT);
    localparam int IDX_W_DEFAULT = $clog2(GAMMA_DEFAULT + 1);

    function automatic int cnt_width(input int gamma);
        return $clog2(gamma);
    endfunction

    // Pulse widths reach GAMMA itself, so the index needs one value more than the counter.
    function automatic int idx_width(input int gamma);
        return $clog2(gamma + 1);
    endfunction

    function automatic mode_t decode_mode(input logic [1:0] raw);
        case (raw)
            2'b01:   return MODE_FALL;
            2'b10:   return MODE_PW;
            default: return MODE_RISE;
        endcase
    endfunction

endpackage

// File: rtl/t_event_capture.sv
// rtl/t_event_capture.sv - per-channel temporal event decoder (edge detect, FSM, width/idx); MUX_T_EARLY_OUT_EN selects pulse-style event_done
module t_event_capture
    import mux_t_pkg::*;
#(
    parameter int GAMMA_CYCLE_WIDTH = GAMMA_DEFAULT,
    parameter int CNT_W             = CNT_W_DEFAULT,
    parameter int IDX_W             = IDX_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] cnt,
    input  logic             boundary,
    input  logic             sel,
    output logic             event_done,
    output logic [IDX_W-1:0] idx
);

    localparam logic [IDX_W-1:0] WIDTH_MAX = IDX_W'(GAMMA_CYCLE_WIDTH);

    chan_state_t      state_q, state_d;
    logic             prev_q, prev_d;
    logic [IDX_W-1:0] width_q, width_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             rise, fall, hit;
    logic [IDX_W-1:0] hit_idx;
    mode_t            mode_e;

    always_comb begin
        mode_e  = decode_mode(mode);
        rise    = sel & ~prev_q;
        fall    = ~sel & prev_q;
        prev_d  = sel;
        state_d = state_q;
        width_d = width_q;
        idx_d   = idx_q;
        hit     = 1'b0;
        hit_idx = idx_q;

        case (state_q)
            IDLE: begin
                case (mode_e)
                    MODE_FALL: begin
                        if (fall) begin
                            hit     = 1'b1;
                            hit_idx = IDX_W'(cnt);
                        end
                    end
                    MODE_PW: begin
                        if (rise) begin
                            state_d = COUNT;
                            width_d = IDX_W'(1);
                        end
                    end
                    default: begin
                        if (rise) begin
                            hit     = 1'b1;
                            hit_idx = IDX_W'(cnt);
                        end
                    end
                endcase
            end
            COUNT: begin
                if (fall) begin
                    hit     = 1'b1;
                    hit_idx = width_q;
                end else if (width_q != WIDTH_MAX) begin
                    width_d = width_q + 1'b1;
                end
            end
            default: ;
        endcase

        if (hit) begin
            state_d = DONE;
            idx_d   = hit_idx;
        end

        // A pulse still high at the boundary is closed out with its current width.
`ifdef MUX_T_EARLY_OUT_EN
        event_done = hit || (boundary && state_d == COUNT);
`else
        event_done = (state_d == DONE) || (boundary && state_d == COUNT);
`endif
        idx = (state_d == COUNT) ? width_d : idx_d;

        if (boundary) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            prev_q  <= 1'b0;
            width_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            width_q <= width_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: rtl/mux_t_multi.sv
// rtl/mux_t_multi.sv - multi-channel temporal-select mux top; MUX_T_EARLY_OUT_EN enables early per-event output updates
module mux_t_multi
    import mux_t_pkg::*;
#(
    parameter int GAMMA_CYCLE_WIDTH = GAMMA_DEFAULT,
    parameter int NUM_INPUTS        = 16,
    parameter int BUS_WIDTH         = 8,
    parameter int NUM_CHANNELS      = 4
) (
    input  logic                                     aclk,
    input  logic                                     grst,
    input  logic [1:0]                               mode,
    input  logic [NUM_INPUTS-1:0][BUS_WIDTH-1:0]     inputs,
    input  logic [NUM_CHANNELS-1:0]                  select_lines,
    output logic [NUM_CHANNELS-1:0][BUS_WIDTH-1:0]   y,
    output logic [NUM_CHANNELS-1:0]                  y_valid,
    output logic                                     gamma_start
);

    localparam int CNT_W = cnt_width(GAMMA_CYCLE_WIDTH);
    localparam int IDX_W = idx_width(GAMMA_CYCLE_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GAMMA_CYCLE_WIDTH - 1);

    logic [CNT_W-1:0]                       cnt_q, cnt_d;
    logic [1:0]                             mode_q, mode_d, mode_eff;
    logic                                   boundary, cycle_start;
    logic [NUM_CHANNELS-1:0]                ev_done;
    logic [NUM_CHANNELS-1:0][IDX_W-1:0]     ev_idx;
    logic [NUM_CHANNELS-1:0][BUS_WIDTH-1:0] y_q, y_d;
    logic [NUM_CHANNELS-1:0]                y_valid_q, y_valid_d;
    logic [BUS_WIDTH-1:0]                   word;
    logic                                   found;

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
        t_event_capture #(
            .GAMMA_CYCLE_WIDTH(GAMMA_CYCLE_WIDTH),
            .CNT_W            (CNT_W),
            .IDX_W            (IDX_W)
        ) u_capture (
            .clk       (aclk),
            .rst       (grst),
            .mode      (mode_eff),
            .cnt       (cnt_q),
            .boundary  (boundary),
            .sel       (select_lines[c]),
            .event_done(ev_done[c]),
            .idx       (ev_idx[c])
        );
    end

    always_comb begin
        cycle_start = (cnt_q == '0);
        boundary    = (cnt_q == CNT_LAST);
        // The mode seen at cnt 0 governs the whole cycle, including events at cnt 0 itself.
        mode_eff    = cycle_start ? mode : mode_q;
        mode_d      = mode_eff;
        cnt_d       = boundary ? '0 : cnt_q + 1'b1;
        y_d         = y_q;
        y_valid_d   = y_valid_q;
        word        = '0;
        found       = 1'b0;

        for (int c = 0; c < NUM_CHANNELS; c++) begin
            word  = '0;
            found = 1'b0;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (int'(ev_idx[c]) == i) begin
                    word  = inputs[i];
                    found = 1'b1;
                end
            end
`ifdef MUX_T_EARLY_OUT_EN
            if (ev_done[c] || boundary) begin
`else
            if (boundary) begin
`endif
                y_d[c]       = (ev_done[c] && found) ? word : '0;
                y_valid_d[c] = ev_done[c] & found;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (grst) begin
            cnt_q     <= '0;
            mode_q    <= 2'b00;
            y_q       <= '0;
            y_valid_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
        end
    end

    assign y           = y_q;
    assign y_valid     = y_valid_q;
    assign gamma_start = cycle_start & ~grst;

endmodule

// File: tb/tb_mux_t_multi.sv
// tb/tb_mux_t_multi.sv - directed self-checking bench for mux_t_multi (default and NUM_INPUTS=8 instances)
module tb_mux_t_multi;

    logic             aclk = 1'b0;
    logic             grst;
    logic [1:0]       mode;
    logic [15:0][7:0] inputs;
    logic [7:0][7:0]  inputs8;
    logic [3:0]       select_lines;
    logic [3:0][7:0]  y, y8;
    logic [3:0]       y_valid, y_valid8;
    logic             gamma_start, gamma_start8;

    int         compared   = 0;
    int         mismatched = 0;
    int         tb_cnt     = 0;
    logic [3:0] pat [16];

    always #5 aclk = ~aclk;

    mux_t_multi dut (
        .aclk(aclk), .grst(grst), .mode(mode), .inputs(inputs),
        .select_lines(select_lines), .y(y), .y_valid(y_valid), .gamma_start(gamma_start)
    );

    mux_t_multi #(.NUM_INPUTS(8)) dut8 (
        .aclk(aclk), .grst(grst), .mode(mode), .inputs(inputs8),
        .select_lines(select_lines), .y(y8), .y_valid(y_valid8), .gamma_start(gamma_start8)
    );

    task automatic step();
        @(posedge aclk);
        #1;
        tb_cnt = (tb_cnt + 1) % 16;
    endtask

    task automatic clear_pat();
        for (int k = 0; k < 16; k++) pat[k] = '0;
    endtask

    task automatic set_high(input int ch, input int from, input int to);
        for (int k = from; k <= to; k++) pat[k][ch] = 1'b1;
    endtask

    task automatic drive_range(input int k0, input int k1);
        for (int k = k0; k < k1; k++) begin
            select_lines = pat[k];
            step();
        end
    endtask

    task automatic test_reset();
        select_lines = '0;
        mode = 2'b00;
        grst = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        compared++; if (y !== 32'h0) begin mismatched++; $display("FAIL reset_y got %h want %h", y, 32'h0); end
        compared++; if (y_valid !== 4'b0) begin mismatched++; $display("FAIL reset_valid got %b want %b", y_valid, 4'b0); end
        compared++; if (gamma_start !== 1'b0) begin mismatched++; $display("FAIL reset_gamma got %b want 0", gamma_start); end
        grst = 1'b0;
        tb_cnt = 0;
        #1;
        compared++; if (gamma_start !== 1'b1) begin mismatched++; $display("FAIL first_gamma got %b want 1", gamma_start); end
        compared++; if (gamma_start8 !== 1'b1) begin mismatched++; $display("FAIL first_gamma8 got %b want 1", gamma_start8); end
        clear_pat();
        drive_range(0, 1);
        compared++; if (gamma_start !== 1'b0) begin mismatched++; $display("FAIL gamma_cnt1 got %b want 0", gamma_start); end
        drive_range(1, 16);
        compared++; if (gamma_start !== 1'b1) begin mismatched++; $display("FAIL gamma_wrap got %b want 1", gamma_start); end
        compared++; if (y_valid !== 4'b0) begin mismatched++; $display("FAIL idle_valid got %b want %b", y_valid, 4'b0); end
    endtask

    task automatic test_rise();
        mode = 2'b00;
        clear_pat();
        set_high(0, 10, 11);
        drive_range(0, 16);
        compared++; if (y !== 32'h0000001A) begin mismatched++; $display("FAIL rise_y got %h want %h", y, 32'h0000001A); end
        compared++; if (y_valid !== 4'b0001) begin mismatched++; $display("FAIL rise_valid got %b want %b", y_valid, 4'b0001); end
        compared++; if (y_valid8 !== 4'b0000) begin mismatched++; $display("FAIL rise_valid8 got %b want %b", y_valid8, 4'b0000); end
        clear_pat();
        drive_range(0, 8);
        compared++; if (y !== 32'h0000001A) begin mismatched++; $display("FAIL rise_hold got %h want %h", y, 32'h0000001A); end
        drive_range(8, 16);
        compared++; if (y !== 32'h0 || y_valid !== 4'b0) begin mismatched++; $display("FAIL rise_clear got %h/%b want 0/0", y, y_valid); end
    endtask

    task automatic test_fall();
        mode = 2'b01;
        clear_pat();
        set_high(1, 3, 6);
        set_high(1, 9, 10);
        set_high(2, 14, 15);
        drive_range(0, 16);
        compared++; if (y !== 32'h00001700) begin mismatched++; $display("FAIL fall_y got %h want %h", y, 32'h00001700); end
        compared++; if (y_valid !== 4'b0010) begin mismatched++; $display("FAIL fall_valid got %b want %b", y_valid, 4'b0010); end
        compared++; if (y8 !== 32'h00001700) begin mismatched++; $display("FAIL fall_y8 got %h want %h", y8, 32'h00001700); end
        clear_pat();
        drive_range(0, 16);
        compared++; if (y !== 32'h00100000) begin mismatched++; $display("FAIL fall_cnt0_y got %h want %h", y, 32'h00100000); end
        compared++; if (y_valid !== 4'b0100) begin mismatched++; $display("FAIL fall_cnt0_valid got %b want %b", y_valid, 4'b0100); end
    endtask

    task automatic test_pulse_width();
        mode = 2'b10;
        clear_pat();
        set_high(2, 4, 8);
        set_high(3, 15, 15);
        drive_range(0, 16);
        compared++; if (y !== 32'h11150000) begin mismatched++; $display("FAIL pw_y got %h want %h", y, 32'h11150000); end
        compared++; if (y_valid !== 4'b1100) begin mismatched++; $display("FAIL pw_valid got %b want %b", y_valid, 4'b1100); end
        clear_pat();
        set_high(3, 0, 2);
        set_high(2, 12, 15);
        drive_range(0, 16);
        compared++; if (y !== 32'h00140000) begin mismatched++; $display("FAIL pw_boundary_y got %h want %h", y, 32'h00140000); end
        compared++; if (y_valid !== 4'b0100) begin mismatched++; $display("FAIL pw_boundary_valid got %b want %b", y_valid, 4'b0100); end
    endtask

    task automatic test_range();
        mode = 2'b00;
        clear_pat();
        set_high(0, 5, 6);
        set_high(3, 9, 10);
        set_high(1, 15, 15);
        drive_range(0, 16);
        compared++; if (y !== 32'h19001F15) begin mismatched++; $display("FAIL range_y got %h want %h", y, 32'h19001F15); end
        compared++; if (y_valid !== 4'b1011) begin mismatched++; $display("FAIL range_valid got %b want %b", y_valid, 4'b1011); end
        compared++; if (y8 !== 32'h00000015) begin mismatched++; $display("FAIL range_y8 got %h want %h", y8, 32'h00000015); end
        compared++; if (y_valid8 !== 4'b0001) begin mismatched++; $display("FAIL range_valid8 got %b want %b", y_valid8, 4'b0001); end
    endtask

    task automatic test_mid_reset();
        mode = 2'b00;
        clear_pat();
        set_high(0, 2, 15);
        drive_range(0, 6);
        select_lines = '0;
        grst = 1'b1;
        @(posedge aclk);
        #1;
        compared++; if (y !== 32'h0 || y_valid !== 4'b0) begin mismatched++; $display("FAIL midrst_out got %h/%b want 0/0", y, y_valid); end
        compared++; if (gamma_start !== 1'b0) begin mismatched++; $display("FAIL midrst_gamma got %b want 0", gamma_start); end
        grst = 1'b0;
        tb_cnt = 0;
        #1;
        compared++; if (gamma_start !== 1'b1) begin mismatched++; $display("FAIL midrst_restart got %b want 1", gamma_start); end
        clear_pat();
        drive_range(0, 16);
        compared++; if (y !== 32'h0 || y_valid !== 4'b0) begin mismatched++; $display("FAIL midrst_stale got %h/%b want 0/0", y, y_valid); end
    endtask

    task automatic test_mode_switch();
        mode = 2'b00;
        clear_pat();
        set_high(0, 7, 8);
        drive_range(0, 5);
        mode = 2'b01;
        drive_range(5, 16);
        compared++; if (y !== 32'h00000017) begin mismatched++; $display("FAIL mode_hold_y got %h want %h", y, 32'h00000017); end
        drive_range(0, 16);
        compared++; if (y !== 32'h00000019) begin mismatched++; $display("FAIL mode_next_y got %h want %h", y, 32'h00000019); end
        compared++; if (y_valid !== 4'b0001) begin mismatched++; $display("FAIL mode_next_valid got %b want %b", y_valid, 4'b0001); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) inputs[i] = 8'(i + 16);
        for (int i = 0; i < 8; i++) inputs8[i] = 8'(i + 16);
        test_reset();
        test_rise();
        test_fall();
        test_pulse_width();
        test_range();
        test_mid_reset();
        test_mode_switch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
